axi_write_arbiter: RTL and testbench

- Shares one downstream AXI write port (AW/W/B) between NUM_REQ upstream write requesters using round-robin arbitration.
- Sits between several write sources and a single AXI write subordinate, e.g. the FIFO-side write subordinate interface.
- Single-beat transactions only. One transaction is in flight at a time.
- The B response is routed back to the requester that owns the transaction.

---
 rtl/axi_write_arbiter_if.sv | 44 ++++
 rtl/axi_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_axi_write_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_write_arbiter_if.sv
// Bus bundle for the write arbiter: per-requester upstream AW/W/B
// channels plus the single shared downstream AXI write port.
interface axi_write_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) ();
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_awaddr;
    logic [NUM_REQ-1:0]            req_awvalid;
    logic [NUM_REQ-1:0]            req_awready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_wvalid;
    logic [NUM_REQ-1:0]            req_wready;
    logic [NUM_REQ*2-1:0]          req_bresp;
    logic [NUM_REQ-1:0]            req_bvalid;
    logic [NUM_REQ-1:0]            req_bready;

    logic [ADDR_WIDTH-1:0]         m_axi_awaddr;
    logic                          m_axi_awvalid;
    logic                          m_axi_awready;
    logic [DATA_WIDTH-1:0]         m_axi_wdata;
    logic                          m_axi_wvalid;
    logic                          m_axi_wready;
    logic                          m_axi_wlast;
    logic [1:0]                    m_axi_bresp;
    logic                          m_axi_bvalid;
    logic                          m_axi_bready;

    modport master (
        input  req_awaddr, req_awvalid, req_wdata, req_wvalid, req_bready,
        output req_awready, req_wready, req_bresp, req_bvalid,
        output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wvalid,
        output m_axi_wlast, m_axi_bready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );

    modport slave (
        output req_awaddr, req_awvalid, req_wdata, req_wvalid, req_bready,
        input  req_awready, req_wready, req_bresp, req_bvalid,
        input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wvalid,
        input  m_axi_wlast, m_axi_bready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );
endinterface

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI write port among
// NUM_REQ requesters; one transaction in flight, B routed to its owner.
module axi_write_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                s_axi_clk,
    input  logic                s_axi_reset,
    axi_write_arbiter_if.master bus,
    output logic [GW-1:0]       grant_id,
    output logic                busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] WAIT_B = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [GW-1:0]         ptr_q, ptr_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            resp_q, resp_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;

    logic [NUM_REQ-1:0]    elig;
    logic [NUM_REQ-1:0]    win_oh;
    logic [NUM_REQ-1:0]    own_oh;
    logic [GW-1:0]         win_idx;
    logic [GW-1:0]         cand;
    logic                  win_found;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  own_bready;
    logic [GW-1:0]         ptr_next;

    assign elig = bus.req_awvalid & bus.req_wvalid;

    // First eligible index at or above the pointer, wrapping at NUM_REQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = GW'((int'(ptr_q) + k) % NUM_REQ);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_oh = (state_q == IDLE && win_found)
                  ? (NUM_REQ'(1) << win_idx) : '0;
    assign own_oh = NUM_REQ'(1) << grant_q;

    assign bus.req_awready = win_oh;
    assign bus.req_wready  = win_oh;

    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_wdata   = data_q;
    assign bus.m_axi_awvalid = (state_q == ISSUE) && !aw_done_q;
    assign bus.m_axi_wvalid  = (state_q == ISSUE) && !w_done_q;
    assign bus.m_axi_wlast   = bus.m_axi_wvalid;
    assign bus.m_axi_bready  = (state_q == WAIT_B);

    assign bus.req_bvalid = (state_q == RESP) ? own_oh : '0;

    always_comb begin
        bus.req_bresp = '0;
        if (state_q == RESP) begin
            bus.req_bresp[grant_q*2 +: 2] = resp_q;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

    assign aw_hs      = bus.m_axi_awvalid && bus.m_axi_awready;
    assign w_hs       = bus.m_axi_wvalid && bus.m_axi_wready;
    assign own_bready = |(bus.req_bready & own_oh);
    assign ptr_next   = (grant_q == GW'(NUM_REQ - 1))
                      ? '0 : grant_q + GW'(1);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        data_d    = data_q;
        resp_d    = resp_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    addr_d    = bus.req_awaddr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    data_d    = bus.req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    grant_d   = win_idx;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WAIT_B;
                end
            end
            WAIT_B: begin
                if (bus.m_axi_bvalid) begin
                    resp_d  = bus.m_axi_bresp;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (own_bready) begin
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_clk or posedge s_axi_reset) begin
        if (s_axi_reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            resp_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            resp_q    <= resp_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed scoreboard bench for axi_write_arbiter (NUM_REQ=2, 8-bit
// address/data) with a hand-driven downstream subordinate.
module tb_axi_write_arbiter;

    logic       clk;
    logic       rst;
    logic [0:0] grant_id;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        sb[$];
    logic [1:0] rsp_q[$];
    int         rsp_g[$];

    axi_write_arbiter_if #(.NUM_REQ(2), .DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    axi_write_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .s_axi_clk   (clk),
        .s_axi_reset (rst),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a,
                           input logic [7:0] d, input logic av,
                           input logic wv);
        bus.req_awaddr[i*8 +: 8] = a;
        bus.req_wdata[i*8 +: 8]  = d;
        bus.req_awvalid[i]       = av;
        bus.req_wvalid[i]        = wv;
    endtask

    // Upstream handshake for expected winner w in the current cycle
    task automatic grant(input int w, input bit drop);
        wr_t e;
        @(negedge clk);
        check("req_awready", 32'(bus.req_awready), 32'(1 << w));
        check("req_wready", 32'(bus.req_wready), 32'(1 << w));
        e.addr = bus.req_awaddr[w*8 +: 8];
        e.data = bus.req_wdata[w*8 +: 8];
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (drop) set_req(w, 8'h00, 8'h00, 1'b0, 1'b0);
        check("grant_id", 32'(grant_id), 32'(w));
        check("busy_granted", 32'(busy), 32'd1);
    endtask

    // Downstream side: AW/W with optional AW stall, then B, then upstream B
    task automatic serve(input int aw_wait, input logic [1:0] resp,
                         input int br_wait, input int g);
        wr_t        e;
        int         cyc;
        bit         aw_ok;
        bit         w_ok;
        logic [1:0] er;
        int         eg;
        e = '0;
        if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
        else e = sb.pop_front();
        aw_ok = 0;
        w_ok  = 0;
        cyc   = 0;
        while (!(aw_ok && w_ok) && cyc < 50) begin
            bus.m_axi_awready = (cyc >= aw_wait);
            bus.m_axi_wready  = 1'b1;
            @(negedge clk);
            check("m_awvalid", 32'(bus.m_axi_awvalid), 32'(!aw_ok));
            check("m_wvalid", 32'(bus.m_axi_wvalid), 32'(!w_ok));
            check("m_wlast", 32'(bus.m_axi_wlast), 32'(!w_ok));
            check("m_bready_issue", 32'(bus.m_axi_bready), 32'd0);
            if (bus.m_axi_awvalid)
                check("m_awaddr", 32'(bus.m_axi_awaddr), 32'(e.addr));
            if (bus.m_axi_wvalid)
                check("m_wdata", 32'(bus.m_axi_wdata), 32'(e.data));
            if (bus.m_axi_awvalid && bus.m_axi_awready) aw_ok = 1;
            if (bus.m_axi_wvalid && bus.m_axi_wready) w_ok = 1;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 50) check("issue_timeout", 32'd0, 32'd1);
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b1;
        bus.m_axi_bresp   = resp;
        rsp_q.push_back(resp);
        rsp_g.push_back(g);
        @(negedge clk);
        check("m_bready_waitb", 32'(bus.m_axi_bready), 32'd1);
        @(posedge clk);
        #1;
        bus.m_axi_bvalid = 1'b0;
        bus.m_axi_bresp  = 2'b00;
        er = rsp_q.pop_front();
        eg = rsp_g.pop_front();
        for (int i = 0; i < br_wait; i++) begin
            @(negedge clk);
            check("req_bvalid_hold", 32'(bus.req_bvalid), 32'(1 << eg));
            check("req_bresp_hold", 32'(bus.req_bresp), 32'(er) << (2*eg));
            check("no_grant_in_resp", 32'(bus.req_awready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.req_bready[g] = 1'b1;
        @(negedge clk);
        check("req_bvalid", 32'(bus.req_bvalid), 32'(1 << eg));
        check("req_bresp", 32'(bus.req_bresp), 32'(er) << (2*eg));
        @(posedge clk);
        #1;
        bus.req_bready = '0;
        check("busy_done", 32'(busy), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awready"}, 32'(bus.req_awready), 32'd0);
        check({tag, "_wready"}, 32'(bus.req_wready), 32'd0);
        check({tag, "_bvalid"}, 32'(bus.req_bvalid), 32'd0);
        check({tag, "_bresp"}, 32'(bus.req_bresp), 32'd0);
        check({tag, "_m_awvalid"}, 32'(bus.m_axi_awvalid), 32'd0);
        check({tag, "_m_wvalid"}, 32'(bus.m_axi_wvalid), 32'd0);
        check({tag, "_m_wlast"}, 32'(bus.m_axi_wlast), 32'd0);
        check({tag, "_m_bready"}, 32'(bus.m_axi_bready), 32'd0);
        check({tag, "_m_awaddr"}, 32'(bus.m_axi_awaddr), 32'd0);
        check({tag, "_m_wdata"}, 32'(bus.m_axi_wdata), 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.req_awaddr    = '0;
        bus.req_awvalid   = '0;
        bus.req_wdata     = '0;
        bus.req_wvalid    = '0;
        bus.req_bready    = '0;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bresp   = 2'b00;
        bus.m_axi_bvalid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;

        // Single write, zero-wait downstream
        set_req(0, 8'h12, 8'hA5, 1'b1, 1'b1);
        grant(0, 1'b1);
        serve(0, 2'b00, 0, 0);

        // Partial valid on req 1, then completed in place
        set_req(1, 8'h21, 8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("partial_awready", 32'(bus.req_awready), 32'd0);
            check("partial_busy", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.req_wvalid[1] = 1'b1;
        grant(1, 1'b1);
        serve(0, 2'b00, 0, 1);

        // AW backpressure for 3 cycles, W accepted first
        set_req(0, 8'h34, 8'h5A, 1'b1, 1'b1);
        grant(0, 1'b1);
        serve(3, 2'b00, 0, 0);

        // SLVERR passthrough with upstream B backpressure
        set_req(1, 8'hC3, 8'h3C, 1'b1, 1'b1);
        grant(1, 1'b1);
        set_req(0, 8'h44, 8'h55, 1'b1, 1'b1);
        serve(0, 2'b10, 4, 1);
        grant(0, 1'b1);
        serve(0, 2'b11, 0, 0);

        // Reset while waiting for B
        set_req(1, 8'h77, 8'h88, 1'b1, 1'b1);
        grant(1, 1'b1);
        bus.m_axi_awready = 1'b1;
        bus.m_axi_wready  = 1'b1;
        @(posedge clk);
        #1;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        @(negedge clk);
        check("waitb_bready", 32'(bus.m_axi_bready), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_idle_outputs("midreset");
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Contention from reset: strict alternation starting at 0
        set_req(0, 8'hA0, 8'h0A, 1'b1, 1'b1);
        set_req(1, 8'hB1, 8'h1B, 1'b1, 1'b1);
        for (int t = 0; t < 4; t++) begin
            grant(t % 2, 1'b0);
            serve(0, 2'(t), 0, t % 2);
        end
        set_req(0, 8'h00, 8'h00, 1'b0, 1'b0);
        set_req(1, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
